// File: rtl/haz_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// forwarding-select values driven onto the ID-stage operand muxes.
package haz_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MDWAIT = 1'b1
    } haz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ID source operand: EX result beats MEM result,
// loads in EX cannot forward yet, and register 0 is never forwarded.
module fwd_sel
    import haz_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] src_Reg_i,
    input  logic [RAW-1:0] ex_Rd_i,
    input  logic           ex_Wreg_i,
    input  logic           ex_Reg2reg_i,
    input  logic [RAW-1:0] mem_Rd_i,
    input  logic           mem_Wreg_i,
    output logic [1:0]     sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (ex_Wreg_i && !ex_Reg2reg_i && (ex_Rd_i != '0) && (ex_Rd_i == src_Reg_i)) begin
            sel_o = FWD_EX;
        end else if (mem_Wreg_i && (mem_Rd_i != '0) && (mem_Rd_i == src_Reg_i)) begin
            sel_o = FWD_MEM;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, mul/div hold
// and ID-stage forwarding. Define HAZ_PERF_CNT_EN to add stall/flush counters.
module pipe_hazard_ctrl
    import haz_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int RAW    = 5
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [RAW-1:0] id_Rs,
    input  logic [RAW-1:0] id_Rt,
    input  logic           id_UseRs,
    input  logic           id_UseRt,
    input  logic           id_MdStart,
    input  logic           id_Taken,
    input  logic [RAW-1:0] ex_Rd,
    input  logic           ex_Wreg,
    input  logic           ex_Reg2reg,
    input  logic [RAW-1:0] mem_Rd,
    input  logic           mem_Wreg,
    output logic           PcEn,
    output logic           IfidEn,
    output logic           IfidClr,
    output logic           IdexEn,
    output logic           IdexClr,
    output logic [1:0]     FwdA,
    output logic [1:0]     FwdB,
    output logic           md_Done,
    output logic           Busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]    StallCnt,
    output logic [31:0]    FlushCnt
`endif
);

    localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    haz_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loadUse;
    logic [1:0]       fwdSelA, fwdSelB;

    fwd_sel #(.RAW(RAW)) u_fwd_a (
        .src_Reg_i    (id_Rs),
        .ex_Rd_i      (ex_Rd),
        .ex_Wreg_i    (ex_Wreg),
        .ex_Reg2reg_i (ex_Reg2reg),
        .mem_Rd_i     (mem_Rd),
        .mem_Wreg_i   (mem_Wreg),
        .sel_o        (fwdSelA)
    );

    fwd_sel #(.RAW(RAW)) u_fwd_b (
        .src_Reg_i    (id_Rt),
        .ex_Rd_i      (ex_Rd),
        .ex_Wreg_i    (ex_Wreg),
        .ex_Reg2reg_i (ex_Reg2reg),
        .mem_Rd_i     (mem_Rd),
        .mem_Wreg_i   (mem_Wreg),
        .sel_o        (fwdSelB)
    );

    // A load in EX cannot forward, so a dependent ID instruction must wait one cycle.
    assign loadUse = ex_Wreg && ex_Reg2reg && (ex_Rd != '0) &&
                     ((id_UseRs && (ex_Rd == id_Rs)) || (id_UseRt && (ex_Rd == id_Rt)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        PcEn    = 1'b1;
        IfidEn  = 1'b1;
        IdexEn  = 1'b1;
        IfidClr = 1'b0;
        IdexClr = 1'b0;
        md_Done = 1'b0;
        Busy    = 1'b0;
        FwdA    = fwdSelA;
        FwdB    = fwdSelB;
        if (Rst) begin
            state_d = RUN;
            cnt_d   = '0;
            PcEn    = 1'b0;
            IfidEn  = 1'b0;
            IdexEn  = 1'b0;
            IfidClr = 1'b1;
            IdexClr = 1'b1;
            FwdA    = FWD_RF;
            FwdB    = FWD_RF;
        end else begin
            case (state_q)
                RUN: begin
                    if (loadUse) begin
                        PcEn    = 1'b0;
                        IfidEn  = 1'b0;
                        IdexClr = 1'b1;
                    end else begin
                        IfidClr = id_Taken;
                        if (id_MdStart) begin
                            cnt_d   = CNT_W'(MD_LAT - 1);
                            state_d = MDWAIT;
                        end
                    end
                end
                MDWAIT: begin
                    PcEn   = 1'b0;
                    IfidEn = 1'b0;
                    IdexEn = 1'b0;
                    Busy   = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        md_Done = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stallCnt_q, flushCnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (!PcEn) stallCnt_q <= stallCnt_q + 32'd1;
            if (IfidClr) flushCnt_q <= flushCnt_q + 32'd1;
        end
    end

    assign StallCnt = stallCnt_q;
    assign FlushCnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-scenario tasks push expected
// output vectors into a scoreboard queue and compare them each cycle.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic       useRs;
        logic [4:0] rt;
        logic       useRt;
        logic       md;
        logic       taken;
        logic [4:0] exRd;
        logic       exW;
        logic       exL;
        logic [4:0] memRd;
        logic       memW;
    } stim_t;

    // Control field order: PcEn, IfidEn, IfidClr, IdexEn, IdexClr
    localparam logic [4:0] C_RUN   = 5'b11010;
    localparam logic [4:0] C_RST   = 5'b00101;
    localparam logic [4:0] C_LU    = 5'b00011;
    localparam logic [4:0] C_TAKEN = 5'b11110;
    localparam logic [4:0] C_WAIT  = 5'b00000;

    logic       Clk;
    logic       Rst;
    logic [4:0] id_Rs, id_Rt, ex_Rd, mem_Rd;
    logic       id_UseRs, id_UseRt, id_MdStart, id_Taken;
    logic       ex_Wreg, ex_Reg2reg, mem_Wreg;
    logic       PcEn, IfidEn, IfidClr, IdexEn, IdexClr, md_Done, Busy;
    logic [1:0] FwdA, FwdB;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    logic [10:0] obsV, expV;
    logic [10:0] expQ[$];
    int          compareCnt = 0;
    int          errCnt = 0;

    pipe_hazard_ctrl #(.MD_LAT(4), .RAW(5)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .id_Rs      (id_Rs),
        .id_Rt      (id_Rt),
        .id_UseRs   (id_UseRs),
        .id_UseRt   (id_UseRt),
        .id_MdStart (id_MdStart),
        .id_Taken   (id_Taken),
        .ex_Rd      (ex_Rd),
        .ex_Wreg    (ex_Wreg),
        .ex_Reg2reg (ex_Reg2reg),
        .mem_Rd     (mem_Rd),
        .mem_Wreg   (mem_Wreg),
        .PcEn       (PcEn),
        .IfidEn     (IfidEn),
        .IfidClr    (IfidClr),
        .IdexEn     (IdexEn),
        .IdexClr    (IdexClr),
        .FwdA       (FwdA),
        .FwdB       (FwdB),
        .md_Done    (md_Done),
        .Busy       (Busy)
`ifdef HAZ_PERF_CNT_EN
        ,
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
`endif
    );

    assign obsV = {PcEn, IfidEn, IfidClr, IdexEn, IdexClr, FwdA, FwdB, md_Done, Busy};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [10:0] mk(input logic [4:0] ctl, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic done, input logic busy);
        return {ctl, fa, fb, done, busy};
    endfunction

    function automatic stim_t mkS(input logic rst, input logic [4:0] rs, input logic useRs,
                                  input logic [4:0] rt, input logic useRt, input logic md,
                                  input logic taken, input logic [4:0] exRd, input logic exW,
                                  input logic exL, input logic [4:0] memRd, input logic memW);
        stim_t s;
        s.rst = rst;     s.rs = rs;       s.useRs = useRs;
        s.rt = rt;       s.useRt = useRt; s.md = md;
        s.taken = taken; s.exRd = exRd;   s.exW = exW;
        s.exL = exL;     s.memRd = memRd; s.memW = memW;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        Rst        = s.rst;
        id_Rs      = s.rs;
        id_UseRs   = s.useRs;
        id_Rt      = s.rt;
        id_UseRt   = s.useRt;
        id_MdStart = s.md;
        id_Taken   = s.taken;
        ex_Rd      = s.exRd;
        ex_Wreg    = s.exW;
        ex_Reg2reg = s.exL;
        mem_Rd     = s.memRd;
        mem_Wreg   = s.memW;
    endtask

    task automatic test_reset();
        stim_t       st[$];
        logic [10:0] ev[$];
        st.push_back(mkS(1, 3,1, 3,1, 0,0, 3,1,0, 3,1)); ev.push_back(mk(C_RST, 2'b00, 2'b00, 0, 0));
        st.push_back(mkS(1, 3,1, 3,1, 1,1, 3,1,0, 3,1)); ev.push_back(mk(C_RST, 2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            expQ.push_back(ev[i]);
            @(negedge Clk);
            expV = expQ.pop_front();
            compareCnt++;
            if (obsV !== expV) begin
                errCnt++;
                $display("[TB] FAIL reset step %0d: got %b expected %b", i, obsV, expV);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t       st[$];
        logic [10:0] ev[$];
        st.push_back(mkS(0, 5,1, 1,1, 1,1, 5,1,1, 0,0)); ev.push_back(mk(C_LU,  2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 5,1, 1,1, 0,0, 0,0,0, 5,1)); ev.push_back(mk(C_RUN, 2'b10, 2'b00, 0, 0));
        st.push_back(mkS(0, 7,0, 7,1, 0,0, 7,1,1, 0,0)); ev.push_back(mk(C_LU,  2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 7,0, 7,0, 0,0, 7,1,1, 0,0)); ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 0,1, 0,1, 0,0, 0,1,1, 0,0)); ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 9,1, 2,1, 0,0, 9,0,1, 0,0)); ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            expQ.push_back(ev[i]);
            @(negedge Clk);
            expV = expQ.pop_front();
            compareCnt++;
            if (obsV !== expV) begin
                errCnt++;
                $display("[TB] FAIL load_use step %0d: got %b expected %b", i, obsV, expV);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_forwarding();
        stim_t       st[$];
        logic [10:0] ev[$];
        st.push_back(mkS(0, 3,1, 3,1, 0,0, 3,1,0, 3,1));    ev.push_back(mk(C_RUN, 2'b01, 2'b01, 0, 0));
        st.push_back(mkS(0, 3,1, 4,1, 0,0, 4,1,0, 3,1));    ev.push_back(mk(C_RUN, 2'b10, 2'b01, 0, 0));
        st.push_back(mkS(0, 0,1, 0,1, 0,0, 0,1,0, 0,1));    ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 6,1, 6,1, 0,0, 6,0,0, 6,1));    ev.push_back(mk(C_RUN, 2'b10, 2'b10, 0, 0));
        st.push_back(mkS(0, 6,1, 8,1, 0,0, 1,1,0, 6,0));    ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 31,1, 30,1, 0,0, 31,1,0, 30,1)); ev.push_back(mk(C_RUN, 2'b01, 2'b10, 0, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            expQ.push_back(ev[i]);
            @(negedge Clk);
            expV = expQ.pop_front();
            compareCnt++;
            if (obsV !== expV) begin
                errCnt++;
                $display("[TB] FAIL forwarding step %0d: got %b expected %b", i, obsV, expV);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_taken();
        stim_t       st[$];
        logic [10:0] ev[$];
        st.push_back(mkS(0, 1,1, 2,1, 0,1, 4,1,1, 0,0)); ev.push_back(mk(C_TAKEN, 2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 4,1, 2,1, 0,1, 4,1,1, 0,0)); ev.push_back(mk(C_LU,    2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 1,1, 2,1, 1,1, 0,0,0, 0,0)); ev.push_back(mk(C_TAKEN, 2'b00, 2'b00, 0, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_WAIT, 2'b00, 2'b00, 0, 1));
        end
        st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_WAIT, 2'b00, 2'b00, 1, 1));
        st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_RUN,  2'b00, 2'b00, 0, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            expQ.push_back(ev[i]);
            @(negedge Clk);
            expV = expQ.pop_front();
            compareCnt++;
            if (obsV !== expV) begin
                errCnt++;
                $display("[TB] FAIL taken step %0d: got %b expected %b", i, obsV, expV);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_muldiv();
        stim_t       st[$];
        logic [10:0] ev[$];
        st.push_back(mkS(0, 0,0, 0,0, 1,0, 0,0,0, 0,0)); ev.push_back(mk(C_RUN,  2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 2,1, 0,0, 1,1, 2,1,0, 0,0)); ev.push_back(mk(C_WAIT, 2'b01, 2'b00, 0, 1));
        st.push_back(mkS(0, 2,1, 0,0, 1,1, 2,1,1, 0,0)); ev.push_back(mk(C_WAIT, 2'b00, 2'b00, 0, 1));
        st.push_back(mkS(0, 2,1, 0,0, 1,1, 2,1,0, 0,0)); ev.push_back(mk(C_WAIT, 2'b01, 2'b00, 0, 1));
        st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_WAIT, 2'b00, 2'b00, 1, 1));
        st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_RUN,  2'b00, 2'b00, 0, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            expQ.push_back(ev[i]);
            @(negedge Clk);
            expV = expQ.pop_front();
            compareCnt++;
            if (obsV !== expV) begin
                errCnt++;
                $display("[TB] FAIL muldiv step %0d: got %b expected %b", i, obsV, expV);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        stim_t       st[$];
        logic [10:0] ev[$];
        st.push_back(mkS(0, 0,0, 0,0, 1,0, 0,0,0, 0,0)); ev.push_back(mk(C_RUN,  2'b00, 2'b00, 0, 0));
        st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_WAIT, 2'b00, 2'b00, 0, 1));
        st.push_back(mkS(1, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_RST,  2'b00, 2'b00, 0, 0));
        for (int k = 0; k < 4; k++) begin
            st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
        end
        foreach (st[i]) begin
            applyStimulus(st[i]);
            expQ.push_back(ev[i]);
            @(negedge Clk);
            expV = expQ.pop_front();
            compareCnt++;
            if (obsV !== expV) begin
                errCnt++;
                $display("[TB] FAIL reset_abort step %0d: got %b expected %b", i, obsV, expV);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t       st[$];
        logic [10:0] ev[$];
        for (int r = 0; r < 2; r++) begin
            st.push_back(mkS(0, 0,0, 0,0, 1,0, 0,0,0, 0,0)); ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
            for (int k = 0; k < 3; k++) begin
                st.push_back(mkS(0, 0,0, 0,0, 1,1, 0,0,0, 0,0)); ev.push_back(mk(C_WAIT, 2'b00, 2'b00, 0, 1));
            end
            st.push_back(mkS(0, 0,0, 0,0, 1,1, 0,0,0, 0,0)); ev.push_back(mk(C_WAIT, 2'b00, 2'b00, 1, 1));
        end
        st.push_back(mkS(0, 0,0, 0,0, 0,0, 0,0,0, 0,0)); ev.push_back(mk(C_RUN, 2'b00, 2'b00, 0, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            expQ.push_back(ev[i]);
            @(negedge Clk);
            expV = expQ.pop_front();
            compareCnt++;
            if (obsV !== expV) begin
                errCnt++;
                $display("[TB] FAIL back_to_back step %0d: got %b expected %b", i, obsV, expV);
            end
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        applyStimulus(mkS(1, 0,0, 0,0, 0,0, 0,0,0, 0,0));
        @(posedge Clk); #1;
        test_reset();
        test_load_use();
        test_forwarding();
        test_taken();
        test_muldiv();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, errCnt);
        $finish;
    end

endmodule
